cmd_axis_upsizer: RTL and testbench

Parametrised AXI-Stream width upsizer for the Ethernet command path. It packs RATIO narrow beats from the command generator into one wide command word, little-endian, for the clock-crossing command FIFO. It also generates per-byte tkeep for short or partial packets, drops whole packets while disabled, and keeps packet and error counters. It sits between the command generator and the command FIFO in the gtx clock domain.

---
 rtl/cmd_axis_upsizer.sv | 161 ++++++++++++++++
 tb/tb_cmd_axis_upsizer.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_axis_upsizer.sv
// cmd_axis_upsizer: packs RATIO narrow AXI-Stream beats into one wide command
// word (little-endian, beat 0 in the LSBs). It builds per-byte tkeep for short
// or partial packets, discards whole packets while disabled, and keeps
// saturating packet, drop and partial counters.
module cmd_axis_upsizer #(
    parameter int S_DWIDTH  = 32,
    parameter int RATIO     = 6,
    parameter int CNT_WIDTH = 16
) (
    input  logic                         axi_tclk,
    input  logic                         axi_treset,
    input  logic                         enable,
    input  logic [S_DWIDTH-1:0]          s_axis_tdata,
    input  logic [S_DWIDTH/8-1:0]        s_axis_tkeep,
    input  logic                         s_axis_tvalid,
    input  logic                         s_axis_tlast,
    output logic                         s_axis_tready,
    output logic [S_DWIDTH*RATIO-1:0]    m_axis_tdata,
    output logic [S_DWIDTH*RATIO/8-1:0]  m_axis_tkeep,
    output logic                         m_axis_tvalid,
    output logic                         m_axis_tlast,
    input  logic                         m_axis_tready,
    output logic [CNT_WIDTH-1:0]         pkt_count,
    output logic [CNT_WIDTH-1:0]         drop_count,
    output logic [CNT_WIDTH-1:0]         partial_count
);

    localparam int SK       = S_DWIDTH / 8;
    localparam int M_DWIDTH = S_DWIDTH * RATIO;
    localparam int MK       = M_DWIDTH / 8;
    localparam int BW       = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [BW-1:0]        LAST_SLOT = BW'(RATIO - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
    localparam logic [SK-1:0]        KEEP_FULL = '1;

    typedef enum logic {
        MODE_DROP = 1'b0,
        MODE_PASS = 1'b1
    } mode_t;

    mode_t                 mode_q;
    logic                  in_pkt_q;
    logic [BW-1:0]         beat_cnt_q;
    logic [M_DWIDTH-1:0]   acc_data_q, acc_data_d;
    logic [MK-1:0]         acc_keep_q, acc_keep_d;
    logic [M_DWIDTH-1:0]   m_data_q;
    logic [MK-1:0]         m_keep_q;
    logic                  m_valid_q;
    logic                  m_last_q;
    logic [CNT_WIDTH-1:0]  pkt_cnt_q, drop_cnt_q, partial_cnt_q;

    logic                  pass_eff;
    logic                  s_ready;
    logic                  beat_acc;
    logic                  m_take;
    logic                  at_last_slot;
    logic                  complete;
    logic [SK-1:0]         beat_keep;
    logic                  pkt_inc, drop_inc, partial_inc;

    // Between packets the mode follows enable directly, so the first beat of a
    // packet is handled with the freshly sampled value; mid-packet the latched
    // mode holds. This also makes the reset value of mode_q irrelevant.
    assign pass_eff     = in_pkt_q ? (mode_q == MODE_PASS) : enable;
    assign s_ready      = pass_eff ? (~m_valid_q | m_axis_tready) : 1'b1;
    assign beat_acc     = s_axis_tvalid & s_ready;
    assign m_take       = m_valid_q & m_axis_tready;
    assign at_last_slot = (beat_cnt_q == LAST_SLOT);
    assign complete     = beat_acc & pass_eff & (at_last_slot | s_axis_tlast);
    assign beat_keep    = s_axis_tlast ? s_axis_tkeep : KEEP_FULL;

    assign pkt_inc      = m_take & m_last_q;
    assign drop_inc     = beat_acc & ~pass_eff & s_axis_tlast;
    assign partial_inc  = complete & s_axis_tlast & (~at_last_slot | (s_axis_tkeep != KEEP_FULL));

    // Accumulator merged with the current beat in slot beat_cnt.
    always_comb begin
        acc_data_d = acc_data_q;
        acc_keep_d = acc_keep_q;
        for (int i = 0; i < RATIO; i++) begin
            if (beat_cnt_q == BW'(i)) begin
                acc_data_d[i*S_DWIDTH +: S_DWIDTH] = s_axis_tdata;
                acc_keep_d[i*SK +: SK]             = beat_keep;
            end
        end
    end

    // Packet tracking, packing and the registered master output stage.
    always_ff @(posedge axi_tclk or posedge axi_treset) begin
        if (axi_treset) begin
            mode_q     <= MODE_DROP;
            in_pkt_q   <= 1'b0;
            beat_cnt_q <= '0;
            acc_data_q <= '0;
            acc_keep_q <= '0;
            m_data_q   <= '0;
            m_keep_q   <= '0;
            m_valid_q  <= 1'b0;
            m_last_q   <= 1'b0;
        end else begin
            if (beat_acc) begin
                in_pkt_q <= ~s_axis_tlast;
                if (!in_pkt_q) begin
                    mode_q <= enable ? MODE_PASS : MODE_DROP;
                end
            end

            if (beat_acc && pass_eff) begin
                if (complete) begin
                    beat_cnt_q <= '0;
                    acc_data_q <= '0;
                    acc_keep_q <= '0;
                end else begin
                    beat_cnt_q <= beat_cnt_q + 1'b1;
                    acc_data_q <= acc_data_d;
                    acc_keep_q <= acc_keep_d;
                end
            end

            // A completing beat can only be accepted when the output slot is
            // free or being taken, so the back-to-back load simply wins.
            if (complete) begin
                m_data_q  <= acc_data_d;
                m_keep_q  <= acc_keep_d;
                m_last_q  <= s_axis_tlast;
                m_valid_q <= 1'b1;
            end else if (m_take) begin
                m_valid_q <= 1'b0;
            end
        end
    end

    // Saturating statistics counters.
    always_ff @(posedge axi_tclk or posedge axi_treset) begin
        if (axi_treset) begin
            pkt_cnt_q     <= '0;
            drop_cnt_q    <= '0;
            partial_cnt_q <= '0;
        end else begin
            if (pkt_inc && (pkt_cnt_q != CNT_MAX)) begin
                pkt_cnt_q <= pkt_cnt_q + 1'b1;
            end
            if (drop_inc && (drop_cnt_q != CNT_MAX)) begin
                drop_cnt_q <= drop_cnt_q + 1'b1;
            end
            if (partial_inc && (partial_cnt_q != CNT_MAX)) begin
                partial_cnt_q <= partial_cnt_q + 1'b1;
            end
        end
    end

    assign s_axis_tready = s_ready;
    assign m_axis_tdata  = m_data_q;
    assign m_axis_tkeep  = m_keep_q;
    assign m_axis_tvalid = m_valid_q;
    assign m_axis_tlast  = m_last_q;
    assign pkt_count     = pkt_cnt_q;
    assign drop_count    = drop_cnt_q;
    assign partial_count = partial_cnt_q;

endmodule

// File: tb/tb_cmd_axis_upsizer.sv
// Bench for cmd_axis_upsizer: directed scenarios plus randomized packets,
// scored against a packet-level model of the expected wide words.
module tb_cmd_axis_upsizer;

    localparam int SW    = 32;
    localparam int RATIO = 6;
    localparam int MW    = SW * RATIO;
    localparam int MKW   = MW / 8;

    typedef struct {
        logic [MW-1:0]  data;
        logic [MKW-1:0] keep;
        logic           last;
    } exp_word_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            enable = 1'b1;
    logic [SW-1:0]   s_data = '0;
    logic [3:0]      s_keep = '0;
    logic            s_valid = 1'b0;
    logic            s_last = 1'b0;
    logic            s_ready;
    logic [MW-1:0]   m_data;
    logic [MKW-1:0]  m_keep;
    logic            m_valid;
    logic            m_last;
    logic            m_ready = 1'b1;
    logic [15:0]     pkt_count, drop_count, partial_count;

    logic            enable2 = 1'b1;
    logic [7:0]      s2_data = '0;
    logic [0:0]      s2_keep = '0;
    logic            s2_valid = 1'b0;
    logic            s2_last = 1'b0;
    logic            s2_ready;
    logic [31:0]     m2_data;
    logic [3:0]      m2_keep;
    logic            m2_valid;
    logic            m2_last;
    logic [15:0]     pkt2, drop2, partial2;

    int              tests = 0;
    int              fails = 0;
    int              exp_pkt = 0, exp_drop = 0, exp_partial = 0;
    exp_word_t       exp_q[$];
    logic            force_low = 1'b0;
    logic            rand_ready = 1'b0;

    logic            held = 1'b0;
    logic [MW-1:0]   hold_data;
    logic [MKW-1:0]  hold_keep;
    logic            hold_last;

    cmd_axis_upsizer #(.S_DWIDTH(SW), .RATIO(RATIO), .CNT_WIDTH(16)) dut (
        .axi_tclk(clk), .axi_treset(rst), .enable(enable),
        .s_axis_tdata(s_data), .s_axis_tkeep(s_keep), .s_axis_tvalid(s_valid),
        .s_axis_tlast(s_last), .s_axis_tready(s_ready),
        .m_axis_tdata(m_data), .m_axis_tkeep(m_keep), .m_axis_tvalid(m_valid),
        .m_axis_tlast(m_last), .m_axis_tready(m_ready),
        .pkt_count(pkt_count), .drop_count(drop_count), .partial_count(partial_count)
    );

    cmd_axis_upsizer #(.S_DWIDTH(8), .RATIO(4), .CNT_WIDTH(16)) dut2 (
        .axi_tclk(clk), .axi_treset(rst), .enable(enable2),
        .s_axis_tdata(s2_data), .s_axis_tkeep(s2_keep), .s_axis_tvalid(s2_valid),
        .s_axis_tlast(s2_last), .s_axis_tready(s2_ready),
        .m_axis_tdata(m2_data), .m_axis_tkeep(m2_keep), .m_axis_tvalid(m2_valid),
        .m_axis_tlast(m2_last), .m_axis_tready(1'b1),
        .pkt_count(pkt2), .drop_count(drop2), .partial_count(partial2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sink readiness: updated just after each rising edge.
    always @(posedge clk) begin
        #1;
        m_ready = force_low ? 1'b0 : (rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
    end

    // Output monitor: stability while stalled, scoreboard on each take.
    always @(negedge clk) begin
        if (rst) begin
            held = 1'b0;
        end else begin
            if (held) begin
                check("hold_valid", 256'(m_valid), 256'(1'b1));
                check("hold_data", 256'(m_data), 256'(hold_data));
                check("hold_keep", 256'(m_keep), 256'(hold_keep));
                check("hold_last", 256'(m_last), 256'(hold_last));
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $error("FAIL unexpected_word observed=%0h expected=none", m_data);
                end else begin
                    exp_word_t e;
                    e = exp_q.pop_front();
                    check("word_data", 256'(m_data), 256'(e.data));
                    check("word_keep", 256'(m_keep), 256'(e.keep));
                    check("word_last", 256'(m_last), 256'(e.last));
                end
            end
            held      = m_valid && !m_ready;
            hold_data = m_data;
            hold_keep = m_keep;
            hold_last = m_last;
        end
    end

    // Called at posedge+1; returns at posedge+1 after the beat was accepted.
    task automatic send_beat(input logic [SW-1:0] d, input logic [3:0] k, input logic l);
        int guard;
        guard   = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_keep  = k;
        s_last  = l;
        @(negedge clk);
        while (!s_ready) begin
            guard++;
            if (guard > 1000) begin
                tests++;
                fails++;
                $error("FAIL send_timeout observed=stalled expected=accept");
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    // Builds the packet, records its expected wide words, then drives it.
    task automatic send_packet(input int n, input logic [3:0] lk, input int base,
                               input logic en, input logic jitter);
        logic [SW-1:0] d[$];
        for (int i = 0; i < n; i++) d.push_back((base != 0) ? SW'(base + i) : SW'($urandom));
        if (en) begin
            for (int w = 0; w * RATIO < n; w++) begin
                exp_word_t e;
                e.data = '0;
                e.keep = '0;
                for (int j = 0; j < RATIO; j++) begin
                    int b;
                    b = w * RATIO + j;
                    if (b < n) begin
                        e.data[j*SW +: SW] = d[b];
                        e.keep[j*4 +: 4]   = (b == n - 1) ? lk : 4'hF;
                    end
                end
                e.last = ((w + 1) * RATIO >= n);
                exp_q.push_back(e);
            end
            exp_pkt++;
            if ((n % RATIO) != 0 || lk != 4'hF) exp_partial++;
        end else begin
            exp_drop++;
        end
        for (int i = 0; i < n; i++) begin
            enable = (i == 0 || !jitter) ? en : 1'($urandom_range(0, 1));
            send_beat(d[i], (i == n - 1) ? lk : 4'($urandom), i == n - 1);
        end
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 3000) begin
            @(posedge clk);
            guard++;
        end
        repeat (3) @(posedge clk);
        #1;
        check("drain_empty", 256'(exp_q.size()), 256'(0));
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_pkt"}, 256'(pkt_count), 256'(exp_pkt));
        check({tag, "_drop"}, 256'(drop_count), 256'(exp_drop));
        check({tag, "_partial"}, 256'(partial_count), 256'(exp_partial));
    endtask

    initial begin
        time t0;
        int  guard;

        // Reset state.
        repeat (3) @(posedge clk);
        #2;
        check("rst_m_valid", 256'(m_valid), 256'(0));
        check("rst_m_data", 256'(m_data), 256'(0));
        check("rst_counters", 256'({pkt_count, drop_count, partial_count}), 256'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_s_ready", 256'(s_ready), 256'(1));
        @(posedge clk);
        #1;

        // Narrow 8-bit / ratio-4 instance: single one-beat packet.
        s2_valid = 1'b1;
        s2_data  = 8'hA5;
        s2_keep  = 1'b1;
        s2_last  = 1'b1;
        @(posedge clk);
        #1;
        s2_valid = 1'b0;
        s2_last  = 1'b0;
        @(negedge clk);
        check("r4_valid", 256'(m2_valid), 256'(1));
        check("r4_data", 256'(m2_data), 256'(32'h0000_00A5));
        check("r4_keep", 256'(m2_keep), 256'(4'h1));
        check("r4_last", 256'(m2_last), 256'(1));
        check("r4_partial", 256'(partial2), 256'(1));
        @(negedge clk);
        check("r4_pkt", 256'(pkt2), 256'(1));
        check("r4_valid_clr", 256'(m2_valid), 256'(0));
        @(posedge clk);
        #1;

        // 12 sequential beats, full throughput.
        t0 = $time;
        send_packet(12, 4'hF, 1, 1'b1, 1'b0);
        check("full_rate_cycles", 256'(($time - t0) / 10), 256'(12));
        drain();
        check_counters("t1");

        // 8-beat packet with a 2-byte final beat.
        send_packet(8, 4'h3, 32'h1000, 1'b1, 1'b0);
        drain();
        check_counters("t2");

        // Backpressure: sink held off for 10 cycles once word0 is valid.
        force_low = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        fork
            send_packet(24, 4'hF, 32'h2000, 1'b1, 1'b0);
            begin
                guard = 0;
                @(negedge clk);
                while (!m_valid && guard < 200) begin
                    guard++;
                    @(negedge clk);
                end
                check("bp_word_seen", 256'(m_valid), 256'(1));
                repeat (10) begin
                    @(negedge clk);
                    check("bp_s_ready", 256'(s_ready), 256'(0));
                end
                force_low = 1'b0;
            end
        join
        drain();
        check_counters("t3");

        // Disabled at packet start; enable raised mid-packet has no effect.
        enable = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i == 2) enable = 1'b1;
            send_beat(SW'(32'h3000 + i), 4'hF, i == 5);
        end
        exp_drop++;
        drain();
        check_counters("t4_drop");
        send_packet(6, 4'hF, 32'h3100, 1'b1, 1'b0);
        drain();
        check_counters("t4_pass");

        // Asynchronous reset mid-packet.
        for (int i = 0; i < 3; i++) send_beat(SW'(32'h4000 + i), 4'hF, 1'b0);
        #3;
        rst = 1'b1;
        #1;
        check("arst_m_valid", 256'(m_valid), 256'(0));
        check("arst_m_data", 256'(m_data), 256'(0));
        check("arst_m_keep", 256'(m_keep), 256'(0));
        check("arst_m_last", 256'(m_last), 256'(0));
        check("arst_counters", 256'({pkt_count, drop_count, partial_count}), 256'(0));
        exp_pkt = 0;
        exp_drop = 0;
        exp_partial = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("arst_s_ready", 256'(s_ready), 256'(1));
        @(posedge clk);
        #1;
        send_packet(6, 4'hF, 32'h5000, 1'b1, 1'b0);
        drain();
        check_counters("t5");

        // Randomized packets, random sink stalls and mid-packet enable jitter.
        rand_ready = 1'b1;
        for (int p = 0; p < 40; p++) begin
            send_packet($urandom_range(1, 20), 4'($urandom_range(1, 15)), 0,
                        ($urandom_range(0, 3) != 0), 1'b1);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        rand_ready = 1'b0;
        drain();
        check_counters("rand");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
